// File: rtl/ber_pkg.sv
// Shared types, default parameters and the saturating-add helper for the BER accumulator.
package ber_pkg;

  localparam int unsigned DATA_W_DEF      = 8;
  localparam int unsigned CNT_W_DEF       = 32;
  localparam int unsigned WIN_BYTES_DEF   = 1024;
  localparam int unsigned SYNC_THRESH_DEF = 4;
  localparam int unsigned SYNC_RUN_DEF    = 8;

  // Working width of the saturating adder; counters up to this width are supported.
  localparam int unsigned SAT_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic             clamp;
    logic [SAT_W-1:0] sum;
  } sat_res_t;

  // a + b clamped to lim; clamp flags that the true sum exceeded lim.
  function automatic sat_res_t sat_add(input logic [SAT_W-1:0] a,
                                       input logic [SAT_W-1:0] b,
                                       input logic [SAT_W-1:0] lim);
    logic [SAT_W:0] full;
    sat_res_t       res;
    full      = {1'b0, a} + {1'b0, b};
    res.clamp = (full > {1'b0, lim});
    res.sum   = res.clamp ? lim : full[SAT_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/ber_accumulator_if.sv
// Control, error-mask and result signals of the BER accumulator.
interface ber_accumulator_if
  import ber_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
);
  logic              start;
  logic              stop;
  logic              err_valid;
  logic [DATA_W-1:0] err_mask;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  err_count;
  logic [CNT_W-1:0]  bit_count;
  logic              overflow;
  logic              sync_lost;

  modport master (
    output start, stop, err_valid, err_mask,
    input  busy, done, err_count, bit_count, overflow, sync_lost
  );

  modport slave (
    input  start, stop, err_valid, err_mask,
    output busy, done, err_count, bit_count, overflow, sync_lost
  );
endinterface

// File: rtl/ber_popcount.sv
// Combinational population count of a DATA_W-bit error mask.
module ber_popcount #(
  parameter  int unsigned DATA_W = 8,
  localparam int unsigned PC_W   = $clog2(DATA_W + 1)
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [PC_W-1:0]   count_c
);

  always_comb begin
    count_c = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      count_c = count_c + PC_W'(data_i[i]);
    end
  end

endmodule

// File: rtl/ber_accumulator.sv
// Windowed bit/error accumulator with saturating counters and done pulse.
// Optional consecutive-bad-byte sync monitor enabled by `define BER_SYNC_MON_EN.
module ber_accumulator
  import ber_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned WIN_BYTES   = WIN_BYTES_DEF,
  parameter int unsigned SYNC_THRESH = SYNC_THRESH_DEF,
  parameter int unsigned SYNC_RUN    = SYNC_RUN_DEF
) (
  input logic               clk,
  input logic               rst_n,
  ber_accumulator_if.slave  bus
);

  localparam int unsigned     PC_W    = $clog2(DATA_W + 1);
  localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'({CNT_W{1'b1}});

  state_t           state_q, state_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             slost_q, slost_d;

  logic [PC_W-1:0]  pop_c;
  logic             beat_c;
  logic             sync_hit_c;
  sat_res_t         err_sum_c;
  sat_res_t         bit_sum_c;
  logic             unused_sum_bits_c;

  ber_popcount #(.DATA_W(DATA_W)) u_popcount (
    .data_i  (bus.err_mask),
    .count_c (pop_c)
  );

  assign beat_c    = (state_q == ST_RUN) && bus.err_valid;
  assign err_sum_c = sat_add(SAT_W'(err_q), SAT_W'(pop_c), CNT_MAX);
  assign bit_sum_c = sat_add(SAT_W'(bit_q), SAT_W'(DATA_W), CNT_MAX);

  // Sums never exceed CNT_MAX, so bits above CNT_W are always zero.
  assign unused_sum_bits_c = ^{err_sum_c.sum[SAT_W-1:CNT_W], bit_sum_c.sum[SAT_W-1:CNT_W]};

`ifdef BER_SYNC_MON_EN
  localparam int unsigned RUN_W = $clog2(SYNC_RUN + 1);

  logic [RUN_W-1:0] run_q, run_d;

  // Length of the current streak of bad bytes; a hit ends the window.
  always_comb begin
    run_d      = run_q;
    sync_hit_c = 1'b0;
    if ((state_q == ST_IDLE) && bus.start) begin
      run_d = '0;
    end else if (beat_c) begin
      if (32'(pop_c) >= SYNC_THRESH) begin
        run_d      = run_q + RUN_W'(1);
        sync_hit_c = (32'(run_d) == SYNC_RUN);
      end else begin
        run_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= '0;
    else        run_q <= run_d;
  end
`else
  logic [63:0] unused_sync_cfg_c;
  assign unused_sync_cfg_c = {32'(SYNC_THRESH), 32'(SYNC_RUN)};
  assign sync_hit_c        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    bit_d   = bit_q;
    beat_d  = beat_q;
    ovf_d   = ovf_q;
    slost_d = slost_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          err_d   = '0;
          bit_d   = '0;
          beat_d  = '0;
          ovf_d   = 1'b0;
          slost_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (beat_c) begin
          err_d  = CNT_W'(err_sum_c.sum);
          bit_d  = CNT_W'(bit_sum_c.sum);
          beat_d = beat_q + CNT_W'(1);
          ovf_d  = ovf_q | err_sum_c.clamp | bit_sum_c.clamp;
        end
        slost_d = slost_q | sync_hit_c;
        // A stop coinciding with a beat still counts that beat.
        if ((beat_c && (beat_d == CNT_W'(WIN_BYTES))) || sync_hit_c || bus.stop) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      err_q   <= '0;
      bit_q   <= '0;
      beat_q  <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      slost_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      bit_q   <= bit_d;
      beat_q  <= beat_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      slost_q <= slost_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err_count = err_q;
  assign bus.bit_count = bit_q;
  assign bus.overflow  = ovf_q;
  assign bus.sync_lost = slost_q;

endmodule
